// File: rtl/toy_cpu_issuer.sv
// Program loader/sequencer for toy_cpu: assembles 3-byte instructions into an
// 8-entry store and replays them one per cycle, once or looping.
module toy_cpu_issuer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       run,
    input  logic       loop,
    input  logic       halt,
    output logic       op_valid,
    output logic [2:0] opcode,
    output logic [2:0] src_a,
    output logic [2:0] src_b,
    output logic [2:0] dest,
    output logic [7:0] imm,
    output logic       busy,
    output logic [2:0] pc,
    output logic [3:0] prog_len,
    output logic       overflow
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_byte_idx;
    logic [5:0]  r_b0, r_b1;
    logic [19:0] r_mem [DEPTH];
    logic        r_op_valid, r_overflow;
    logic [19:0] r_fields;
    logic [2:0]  r_pc;
    logic [3:0]  r_prog_len;
    logic        w_take, w_wr, w_last;

    // entry layout: {imm, dest, src_b, src_a, opcode}
    always_comb begin
        w_take      = (r_state == S_LOAD) && load && in_valid;
        w_wr        = w_take && (r_byte_idx == 2'd2) && (r_prog_len < 4'(DEPTH));
        w_last      = ({1'b0, r_pc} == (r_prog_len - 4'd1));
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load)
                    w_state_nxt = S_LOAD;
                else if (run && (r_prog_len != 4'd0))
                    w_state_nxt = S_RUN;
            end
            S_LOAD: begin
                if (!load)
                    w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (halt || (w_last && !loop))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_idx <= 2'd0;
            r_b0       <= 6'd0;
            r_b1       <= 6'd0;
            r_op_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_fields   <= 20'd0;
            r_pc       <= 3'd0;
            r_prog_len <= 4'd0;
        end else begin
            r_op_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_prog_len <= 4'd0;
                        r_byte_idx <= 2'd0;
                        r_overflow <= 1'b0;
                    end else if (run && (r_prog_len != 4'd0)) begin
                        r_pc <= 3'd0;
                    end
                end
                S_LOAD: begin
                    if (!load) begin
                        r_byte_idx <= 2'd0;
                    end else if (w_take) begin
                        case (r_byte_idx)
                            2'd0:    begin r_b0 <= in_byte[5:0]; r_byte_idx <= 2'd1; end
                            2'd1:    begin r_b1 <= in_byte[5:0]; r_byte_idx <= 2'd2; end
                            default: begin
                                r_byte_idx <= 2'd0;
                                if (w_wr)
                                    r_prog_len <= r_prog_len + 4'd1;
                                else
                                    r_overflow <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (!halt) begin
                        r_fields   <= r_mem[r_pc];
                        r_op_valid <= 1'b1;
                        // wrap to 0 on the last entry whether looping or leaving
                        r_pc       <= w_last ? 3'd0 : r_pc + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // program store is deliberately not reset so a program survives reruns
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_prog_len[2:0]] <= {in_byte, r_b1, r_b0};
    end

    assign op_valid = r_op_valid;
    assign opcode   = r_fields[2:0];
    assign src_a    = r_fields[5:3];
    assign src_b    = r_fields[8:6];
    assign dest     = r_fields[11:9];
    assign imm      = r_fields[19:12];
    assign busy     = (r_state != S_IDLE);
    assign pc       = r_pc;
    assign prog_len = r_prog_len;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_toy_cpu_issuer.sv
// Scoreboard bench for toy_cpu_issuer: a queue-based program model predicts
// every issued instruction; a negedge monitor pops and compares.
module tb_toy_cpu_issuer;

    typedef struct packed {
        logic [2:0] op, a, b, d;
        logic [7:0] imm;
    } ins_t;

    logic       clk = 1'b0, rst = 1'b0;
    logic       load = 1'b0, in_valid = 1'b0, run = 1'b0, loop = 1'b0, halt = 1'b0;
    logic [7:0] in_byte = 8'd0;
    logic       op_valid, busy, overflow;
    logic [2:0] opcode, src_a, src_b, dest, pc;
    logic [7:0] imm;
    logic [3:0] prog_len;

    int checks = 0, errors = 0;
    ins_t model_prog[$];
    ins_t expq[$];
    logic [7:0] part[$];
    logic model_ovf = 1'b0;

    toy_cpu_issuer #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .load(load), .in_valid(in_valid), .in_byte(in_byte),
        .run(run), .loop(loop), .halt(halt), .op_valid(op_valid), .opcode(opcode),
        .src_a(src_a), .src_b(src_b), .dest(dest), .imm(imm), .busy(busy), .pc(pc),
        .prog_len(prog_len), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // monitor: every issued instruction must match the head of the expected queue
    always @(negedge clk) begin
        if (rst && op_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got op=%0d a=%0d b=%0d d=%0d imm=%h, expected none",
                         opcode, src_a, src_b, dest, imm);
            end else begin
                ins_t e;
                e = expq.pop_front();
                if ({opcode, src_a, src_b, dest, imm} !== e) begin
                    errors++;
                    $display("FAIL issue_fields: got op=%0d a=%0d b=%0d d=%0d imm=%h, expected op=%0d a=%0d b=%0d d=%0d imm=%h",
                             opcode, src_a, src_b, dest, imm, e.op, e.a, e.b, e.d, e.imm);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ins_t dec(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        ins_t r;
        r.op  = b0[2:0];
        r.a   = b0[5:3];
        r.b   = b1[2:0];
        r.d   = b1[5:3];
        r.imm = b2;
        return r;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t r;
        r = ins_t'($urandom);
        return r;
    endfunction

    task automatic start_load();
        load = 1'b1;
        tick();
        model_prog.delete();
        part.delete();
        model_ovf = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] bb, input bit gaps);
        in_valid = 1'b1;
        in_byte  = bb;
        tick();
        in_valid = 1'b0;
        part.push_back(bb);
        if (part.size() == 3) begin
            if (model_prog.size() < 8) model_prog.push_back(dec(part[0], part[1], part[2]));
            else model_ovf = 1'b1;
            part.delete();
        end
        if (gaps && $urandom_range(0, 3) == 0) tick();
    endtask

    task automatic send_ins(input ins_t x, input bit gaps);
        logic [1:0] t0, t1;
        t0 = 2'($urandom);
        t1 = 2'($urandom);
        send_byte({t0, x.a, x.op}, gaps);
        send_byte({t1, x.d, x.b}, gaps);
        send_byte(x.imm, gaps);
    endtask

    // leaving LOAD with in_valid high: that byte must be ignored
    task automatic end_load();
        load     = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'($urandom);
        tick();
        in_valid = 1'b0;
        part.delete();
    endtask

    task automatic run_once(input string name);
        int n;
        loop = 1'b0;
        run  = 1'b1;
        foreach (model_prog[i]) expq.push_back(model_prog[i]);
        tick();
        run = 1'b0;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        chk({name, "_busy_end"}, busy, 0);
        tick();
        chk({name, "_opv_gap"}, op_valid, 0);
        chk({name, "_drained"}, expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        ins_t i0, i1;
        // reset state
        tick(); tick();
        chk("reset_outputs", {op_valid, opcode, src_a, src_b, dest, imm, busy, pc, prog_len, overflow}, 0);
        rst = 1'b1;
        tick();

        // empty run: no issue
        run = 1'b1; tick(); run = 1'b0; tick();
        chk("empty_run_busy", busy, 0);

        // load and run the two fixed instructions
        i0 = '{op: 3'd1, a: 3'd2, b: 3'd3, d: 3'd4, imm: 8'h5A};
        i1 = '{op: 3'd6, a: 3'd7, b: 3'd0, d: 3'd1, imm: 8'hFF};
        start_load();
        send_ins(i0, 1'b0);
        send_ins(i1, 1'b0);
        end_load();
        chk("basic_prog_len", prog_len, 2);
        run_once("basic");
        chk("basic_prog_len_after", prog_len, 2);
        run_once("rerun");

        // load and run together in IDLE: load wins
        load = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        model_prog.delete(); part.delete(); model_ovf = 1'b0;
        chk("prio_busy", busy, 1);
        chk("prio_prog_len", prog_len, 0);
        tick();
        // overflow: 9 instructions, only first 8 kept
        for (int k = 0; k < 9; k++) send_ins(rnd_ins(), 1'b1);
        end_load();
        chk("ovf_prog_len", prog_len, 8);
        chk("ovf_flag", overflow, model_ovf);
        run_once("ovf_run");

        // partial discard and realignment
        start_load();
        chk("ovf_cleared", overflow, 0);
        send_ins(rnd_ins(), 1'b0);
        send_byte(8'($urandom), 1'b0);
        end_load();
        chk("partial_prog_len", prog_len, 1);
        start_load();
        send_ins(rnd_ins(), 1'b0);
        end_load();
        chk("realign_prog_len", prog_len, 1);
        run_once("realign");

        // loop and halt on a 3-entry program
        start_load();
        for (int k = 0; k < 3; k++) send_ins(rnd_ins(), 1'b1);
        end_load();
        loop = 1'b1;
        for (int k = 0; k < 7; k++) expq.push_back(model_prog[k % 3]);
        run = 1'b1; tick(); run = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        halt = 1'b1; tick(); halt = 1'b0; loop = 1'b0;
        chk("halt_opv", op_valid, 0);
        chk("halt_busy", busy, 0);
        tick();
        chk("loop_drained", expq.size(), 0);
        expq.delete();

        // reset mid-RUN: only entry 0 reaches the monitor
        loop = 1'b1;
        expq.push_back(model_prog[0]);
        run = 1'b1; tick(); run = 1'b0;
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", {op_valid, opcode, src_a, src_b, dest, imm, busy, pc, prog_len, overflow}, 0);
        loop = 1'b0;
        model_prog.delete();
        tick();
        chk("rst_drained", expq.size(), 0);
        expq.delete();
        #3 rst = 1'b1;
        tick();
        run = 1'b1; tick(); run = 1'b0; tick();
        chk("post_reset_run_busy", busy, 0);

        // randomized programs
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 9);
            start_load();
            for (int k = 0; k < n; k++) send_ins(rnd_ins(), 1'b1);
            end_load();
            chk("rnd_prog_len", prog_len, model_prog.size());
            chk("rnd_ovf", overflow, model_ovf);
            run_once("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toy_cpu_issuer.md
# toy_cpu_issuer

Instruction loader and sequencer that drives the `toy_cpu` issue interface (`op_valid`, `opcode`, `src_a`, `src_b`, `dest`, `imm`).
- Accepts a byte-serial program from the chip input pins and assembles each instruction from 3 bytes.
- Stores up to 8 instructions.
- On command, replays them to the CPU at one instruction per cycle, once or looping.
- Sits between the top-level pin mux and `toy_cpu`.

## Interface
- `DEPTH`, 8: program entries; fixed at 8, pointers are 3 bits, `prog_len` is 4 bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `load` input 1: level; high selects program-load mode.
- `in_valid` input 1: `in_byte` qualifier during load.
- `in_byte` input 8: program byte stream.
- `run` input 1: start execution; sampled in IDLE.
- `loop` input 1: sampled when the last entry issues; 1 wraps to entry 0.
- `halt` input 1: aborts RUN.
- `op_valid` output 1: registered; high for exactly one cycle per issued instruction.
- `opcode`, `src_a`, `src_b`, `dest` output 3 each: registered instruction fields.
- `imm` output 8: registered immediate.
- `busy` output 1: high when state is not IDLE.
- `pc` output 3: index of the next entry to issue.
- `prog_len` output 4: stored instruction count, 0..8.
- `overflow` output 1: sticky; a 9th or later instruction was dropped.

## Operation
- **Byte format**, sent in order 0, 1, 2:
  - byte0 = {2'b00, `src_a`[2:0], `opcode`[2:0]}
  - byte1 = {2'b00, `dest`[2:0], `src_b`[2:0]}
  - byte2 = `imm`[7:0]
  - Bits [7:6] of byte0 and byte1 are ignored.
- **States:** IDLE, LOAD, RUN.
- **IDLE:**
  - `load`=1 → LOAD; clears `prog_len`, `byte_idx` and `overflow`.
  - Else `run`=1 with `prog_len`≠0 → RUN; sets `pc`=0.
  - `run`=1 with `prog_len`=0 → stays IDLE.
  - `load` has priority over `run`.
- **LOAD:**
  - Each cycle with `in_valid`=1 stores `in_byte` into assembly slot `byte_idx`; `byte_idx` counts 0→1→2→0.
  - On the edge that accepts byte2:
    - if `prog_len`<8, write entry[`prog_len`] and increment `prog_len`;
    - else discard the instruction and set `overflow`=1.
  - `load`=0 → IDLE at that edge. A partial instruction is discarded, `byte_idx` is reset to 0, and `in_valid` is ignored in that cycle.
  - `run` and `halt` are ignored in LOAD.
- **RUN:** each edge registers entry[`pc`] onto the field outputs and sets `op_valid`=1.
  - If `pc`≠`prog_len`−1: `pc` increments.
  - At `pc`=`prog_len`−1 with `loop`=1: `pc` wraps to 0 and the block stays in RUN.
  - At `pc`=`prog_len`−1 with `loop`=0: → IDLE.
  - `halt`=1 → IDLE at that edge with no issue (`op_valid` is 0 next cycle). `halt` has priority over issue.
- Field outputs hold their last issued values while `op_valid`=0.
- `overflow` holds until the next LOAD entry or reset.
- Program memory is not reset. It survives LOAD exit and can be rerun any number of times without reloading.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - State = IDLE.
  - `op_valid`, `opcode`, `src_a`, `src_b`, `dest`, `imm`, `pc`, `prog_len`, `overflow`, `busy` = 0.
  - Internal `byte_idx` = 0.
  - Takes effect immediately, including mid-RUN and mid-LOAD.
  - Assertion mid-RUN drops `op_valid` without waiting for a clock edge.
- **Run latency:** `run` sampled at edge N (IDLE→RUN); entries 0..L−1 issue at edges N+1..N+L.
  - `op_valid` is high in the L consecutive cycles following those edges.
  - At edge N+L the state returns to IDLE, and `op_valid` falls at edge N+L+1.
- **Looping:** back-to-back issue with no gap; entry 0 follows entry L−1 on the next edge.
- **Earliest restart:** the earliest new `run` is sampled at edge N+L+1, giving a 1-cycle `op_valid` gap between runs.
- **Load throughput:** one byte per cycle; a full 8-instruction program takes 24 `in_valid` cycles.
- **Write visibility:** a freshly written entry is readable one cycle after its byte2 edge.

## Test plan
- **Load and run:**
  - Stimulus: load 2 instructions {op=1, a=2, b=3, d=4, imm=0x5A} and {op=6, a=7, b=0, d=1, imm=0xFF}, drop `load`, pulse `run`.
  - Required: `op_valid` high exactly 2 cycles carrying those fields in order, then `busy`=0, `prog_len`=2.
- **Overflow:**
  - Stimulus: load 9 instructions.
  - Required: `prog_len`=8 and `overflow`=1; a subsequent run issues only the first 8 entries.
- **Partial discard:**
  - Stimulus: send 4 bytes, then drop `load`.
  - Required: `prog_len`=1.
  - Stimulus: reload with 3 bytes.
  - Required: the entry decodes from those 3 new bytes, with no byte misalignment.
- **Loop and halt:**
  - Stimulus: 3-entry program with `loop`=1 and `run` pulsed; assert `halt` after 7 issues.
  - Required: issue order 0,1,2,0,1,2,0; `op_valid`=0 the cycle after the `halt` edge; `busy`=0.
- **Reset mid-RUN:**
  - Stimulus: assert `rst`=0 between clock edges.
  - Required: all outputs 0 immediately.
  - Stimulus: `run` after release.
  - Required: stays IDLE, because `prog_len`=0.
- **Empty and priority:**
  - Stimulus: `run`=1 with `prog_len`=0.
  - Required: no issue.
  - Stimulus: `load`=1 and `run`=1 together in IDLE.
  - Required: enters LOAD.
